wb_cpu_bus_bridge: RTL and testbench
====================================

Name: wb_cpu_bus_bridge

Overview:
- Second-generation Wishbone master bridge between an 8-bit CPU core (Arlet-style 6502 bus) and the system Wishbone fabric.
- Runtime-programmable CPU step rate replaces the fixed free-running divider.
- Performs a real cyc/stb/ack handshake per CPU bus cycle and stalls the CPU (ready low) until the slave acknowledges.
- Sits between the CPU core and the address decoder/RAM/TIA/RIOT slaves.

Parameters:
- WB_DATA_WIDTH, 8, Wishbone and CPU data width.
- WB_ADDR_WIDTH, 16, Wishbone and CPU address width.
- CLK_DIV_BITS, 8, width of the step divider counter and div_i.
- TIMEOUT_CYCLES, 255, maximum REQ cycles before abort (only with WB_TIMEOUT_EN); must fit in 16 bits.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  Wishbone write enable.
- adr_o  out  WB_ADDR_WIDTH  Wishbone address.
- dat_o  out  WB_DATA_WIDTH  Wishbone write data.
- ack_i  in  1  Wishbone acknowledge.
- dat_i  in  WB_DATA_WIDTH  Wishbone read data.
- address_bus  in  WB_ADDR_WIDTH  CPU address.
- write_bus  in  WB_DATA_WIDTH  CPU write data.
- write_enable  in  1  CPU write request.
- read_bus  out  WB_DATA_WIDTH  registered read data to CPU.
- ready  out  1  one-cycle CPU clock-enable pulse.
- div_i  in  CLK_DIV_BITS  idle cycles inserted before each bus cycle.
- halt_i  in  1  debug freeze; holds bridge in IDLE.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is asynchronous and active-low.
- Reset values (asynchronous, applied immediately on rst_ni low):
  - cyc_o=0, stb_o=0, we_o=0, adr_o=0, dat_o=0, read_bus=0, ready=0, err_o=0.
  - Divider count cnt=0, state=IDLE.
- Reset mid-REQ drops cyc_o/stb_o in the same instant; the transaction is abandoned and no ready pulse is issued.

State machine (3 states):
- IDLE:
  - If halt_i=1: hold; cnt is not incremented.
  - Else if cnt==div_i: latch address_bus->adr_o, write_bus->dat_o, write_enable->we_o; set cyc_o=stb_o=1; go REQ.
  - Else cnt<=cnt+1.
- REQ:
  - cyc_o/stb_o held high; adr_o/dat_o/we_o stable.
  - On ack_i=1: if we_o=0, read_bus<=dat_i (read_bus is unchanged on writes). Clear cyc_o/stb_o/we_o; go DONE.
  - A transaction takes at least 1 REQ cycle; zero-wait slaves ack in the first REQ cycle.
- DONE:
  - ready=1 for exactly this cycle; cnt<=0; go IDLE.
  - halt_i does not suppress a pending DONE.

Timing and boundary rules:
- ready is 0 in every other state.
- CPU step period = (div_i+1) + N_wait_REQ + 1 clk_i cycles, where N_wait_REQ >= 1.
- div_i=0: IDLE lasts exactly 1 cycle.
- div_i all-ones: no wrap; cnt reaches div_i and starts the transaction.
- div_i is sampled every IDLE cycle. Changing it mid-count takes effect immediately. If the new value is below cnt, the count runs to all-ones, wraps to 0, and matches on reaching div_i; this is accepted behaviour.
- ack_i outside REQ is ignored.
- CPU inputs are sampled only on the IDLE->REQ transition; changes during REQ/DONE are ignored.
- err_o is cleared only by reset.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter is cleared on entering REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: read_bus<=all-ones (if read), err_o<=1 (sticky), cyc_o/stb_o/we_o cleared, go DONE (the CPU continues).
  - ack_i arriving in the same cycle as the timeout wins: normal completion, err_o unchanged.
- Undefined: REQ waits indefinitely; err_o is tied 0; no counter logic.

Test Plan:
- Reset then release, div_i=3, slave acks in the first REQ cycle, CPU reads 0x1234 with dat_i=0xA5 -> cyc_o/stb_o rise 4 cycles after release, adr_o=0x1234, we_o=0, read_bus=0xA5, ready pulses once, period 6 cycles.
- CPU write 0x0080<=0x5A, slave delays ack 3 cycles -> we_o=1, dat_o=0x5A stable for all 4 REQ cycles, read_bus unchanged, ready pulses one cycle after ack.
- div_i=0, back-to-back reads with a zero-wait slave -> ready every 3 cycles; no ready while stb_o=1.
- halt_i asserted during IDLE for 10 cycles -> cyc_o stays 0, no ready; after release the transaction starts once cnt==div_i.
- rst_ni pulsed low during REQ -> cyc_o/stb_o drop immediately, all outputs at reset values, no ready.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks a read -> abort after 8 REQ cycles, read_bus=0xFF, err_o=1 and stays 1, next CPU cycle proceeds normally.

Source files
------------

// File: rtl/wb_cpu_bus_bridge.sv
// Wishbone master bridge for an 8-bit 6502-style CPU bus with a programmable step rate.
// Optional REQ timeout abort is enabled by defining WB_TIMEOUT_EN.
module wb_cpu_bus_bridge #(
   parameter int WB_DATA_WIDTH  = 8,
   parameter int WB_ADDR_WIDTH  = 16,
   parameter int CLK_DIV_BITS   = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   output logic                     cyc_o,
   output logic                     stb_o,
   output logic                     we_o,
   output logic [WB_ADDR_WIDTH-1:0] adr_o,
   output logic [WB_DATA_WIDTH-1:0] dat_o,
   input  logic                     ack_i,
   input  logic [WB_DATA_WIDTH-1:0] dat_i,
   input  logic [WB_ADDR_WIDTH-1:0] address_bus,
   input  logic [WB_DATA_WIDTH-1:0] write_bus,
   input  logic                     write_enable,
   output logic [WB_DATA_WIDTH-1:0] read_bus,
   output logic                     ready,
   input  logic [CLK_DIV_BITS-1:0]  div_i,
   input  logic                     halt_i,
   output logic                     err_o
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   state_t                  state;
   logic [CLK_DIV_BITS-1:0] cnt;

`ifdef WB_TIMEOUT_EN
   // The abort fires in the REQ cycle that would otherwise push the count to TIMEOUT_CYCLES.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt;
`else
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         cnt      <= '0;
         cyc_o    <= 1'b0;
         stb_o    <= 1'b0;
         we_o     <= 1'b0;
         adr_o    <= '0;
         dat_o    <= '0;
         read_bus <= '0;
         ready    <= 1'b0;
`ifdef WB_TIMEOUT_EN
         tmo_cnt  <= '0;
         err_o    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!halt_i) begin
                  // CPU bus signals are captured only here, so they may change freely afterwards.
                  if (cnt == div_i) begin
                     adr_o <= address_bus;
                     dat_o <= write_bus;
                     we_o  <= write_enable;
                     cyc_o <= 1'b1;
                     stb_o <= 1'b1;
                     state <= REQ;
`ifdef WB_TIMEOUT_EN
                     tmo_cnt <= '0;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            REQ: begin
               if (ack_i) begin
                  if (!we_o) begin
                     read_bus <= dat_i;
                  end
                  cyc_o <= 1'b0;
                  stb_o <= 1'b0;
                  we_o  <= 1'b0;
                  ready <= 1'b1;
                  state <= DONE;
               end
`ifdef WB_TIMEOUT_EN
               else if (tmo_cnt == TIMEOUT_LAST) begin
                  if (!we_o) begin
                     read_bus <= '1;
                  end
                  err_o <= 1'b1;
                  cyc_o <= 1'b0;
                  stb_o <= 1'b0;
                  we_o  <= 1'b0;
                  ready <= 1'b1;
                  state <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
`endif
            end
            DONE: begin
               ready <= 1'b0;
               cnt   <= '0;
               state <= IDLE;
            end
            default: begin
               ready <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cpu_bus_bridge.sv
// Directed self-checking bench for wb_cpu_bus_bridge with a small wait-state Wishbone slave.
module tb_wb_cpu_bus_bridge;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cyc_o, stb_o, we_o;
   logic [15:0] adr_o;
   logic [7:0]  dat_o;
   logic        ack_i;
   logic [7:0]  dat_i = 8'h00;
   logic [15:0] address_bus = 16'h0000;
   logic [7:0]  write_bus = 8'h00;
   logic        write_enable = 1'b0;
   logic [7:0]  read_bus;
   logic        ready;
   logic [7:0]  div_i = 8'd0;
   logic        halt_i = 1'b0;
   logic        err_o;

   int   checks = 0;
   int   errors = 0;

   int   ackDelay = 0;
   logic ackEnable = 1'b1;
   logic ackForce = 1'b0;
   int   waitCnt;

   wb_cpu_bus_bridge #(
      .WB_DATA_WIDTH (8),
      .WB_ADDR_WIDTH (16),
      .CLK_DIV_BITS  (8),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cyc_o       (cyc_o),
      .stb_o       (stb_o),
      .we_o        (we_o),
      .adr_o       (adr_o),
      .dat_o       (dat_o),
      .ack_i       (ack_i),
      .dat_i       (dat_i),
      .address_bus (address_bus),
      .write_bus   (write_bus),
      .write_enable(write_enable),
      .read_bus    (read_bus),
      .ready       (ready),
      .div_i       (div_i),
      .halt_i      (halt_i),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Slave acks after ackDelay wait cycles; ackForce injects a stray ack.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) waitCnt <= 0;
      else if (cyc_o && stb_o && !ack_i) waitCnt <= waitCnt + 1;
      else waitCnt <= 0;
   end
   assign ack_i = ackForce | (ackEnable & cyc_o & stb_o & (waitCnt == ackDelay));

   task automatic applyReset();
      rst_ni = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      #1;
      checks++; if (cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_cyc: got %b expected 0", cyc_o); end
      checks++; if (stb_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stb: got %b expected 0", stb_o); end
      checks++; if (we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", we_o); end
      checks++; if (adr_o !== 16'h0) begin errors++; $display("[TB] FAIL reset_adr: got %h expected 0000", adr_o); end
      checks++; if (dat_o !== 8'h0) begin errors++; $display("[TB] FAIL reset_dat: got %h expected 00", dat_o); end
      checks++; if (read_bus !== 8'h0) begin errors++; $display("[TB] FAIL reset_read_bus: got %h expected 00", read_bus); end
      checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
   endtask

   task automatic test_read();
      int firstCyc = -1, firstReady = -1, secondReady = -1, readyCount = 0;
      logic [15:0] seenAdr = 16'h0;
      logic seenWe = 1'b1;
      logic [7:0] seenRead = 8'h0;
      applyReset();
      div_i = 8'd3; ackDelay = 0; address_bus = 16'h1234; write_enable = 1'b0; dat_i = 8'hA5;
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk_i);
         if (cyc_o && firstCyc < 0) begin firstCyc = i; seenAdr = adr_o; seenWe = we_o; end
         if (ready) begin
            readyCount++;
            if (firstReady < 0) begin firstReady = i; seenRead = read_bus; end
            else if (secondReady < 0) secondReady = i;
         end
      end
      checks++; if (firstCyc !== 4) begin errors++; $display("[TB] FAIL read_cyc_start: got %0d expected 4", firstCyc); end
      checks++; if (seenAdr !== 16'h1234) begin errors++; $display("[TB] FAIL read_adr: got %h expected 1234", seenAdr); end
      checks++; if (seenWe !== 1'b0) begin errors++; $display("[TB] FAIL read_we: got %b expected 0", seenWe); end
      checks++; if (firstReady !== 5) begin errors++; $display("[TB] FAIL read_ready_cycle: got %0d expected 5", firstReady); end
      checks++; if (seenRead !== 8'hA5) begin errors++; $display("[TB] FAIL read_data: got %h expected a5", seenRead); end
      checks++; if (secondReady - firstReady !== 6) begin errors++; $display("[TB] FAIL read_period: got %0d expected 6", secondReady - firstReady); end
      checks++; if (readyCount !== 2) begin errors++; $display("[TB] FAIL read_ready_count: got %0d expected 2", readyCount); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL read_err: got %b expected 0", err_o); end
   endtask

   task automatic test_write();
      int reqCycles = 0, badHold = 0, ackCycle = -1, readyCycle = -1;
      applyReset();
      div_i = 8'd3; ackDelay = 3; address_bus = 16'h0080; write_bus = 8'h5A; write_enable = 1'b1; dat_i = 8'h77;
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 1; i <= 20 && readyCycle < 0; i++) begin
         @(negedge clk_i);
         if (i == 5) begin write_bus = 8'hC3; address_bus = 16'hFFFF; end
         if (cyc_o) begin
            reqCycles++;
            if (we_o !== 1'b1 || dat_o !== 8'h5A || adr_o !== 16'h0080) badHold++;
            if (ack_i) ackCycle = i;
         end
         if (ready) readyCycle = i;
      end
      write_enable = 1'b0; ackDelay = 0;
      checks++; if (reqCycles !== 4) begin errors++; $display("[TB] FAIL write_req_cycles: got %0d expected 4", reqCycles); end
      checks++; if (badHold !== 0) begin errors++; $display("[TB] FAIL write_hold: got %0d unstable cycles expected 0", badHold); end
      checks++; if (readyCycle !== ackCycle + 1 || readyCycle < 0) begin errors++; $display("[TB] FAIL write_ready_after_ack: got %0d expected %0d", readyCycle, ackCycle + 1); end
      checks++; if (read_bus !== 8'h00) begin errors++; $display("[TB] FAIL write_read_bus: got %h expected 00", read_bus); end
   endtask

   task automatic test_back_to_back();
      int readyCount = 0, prevReady = -1, badGap = 0, overlap = 0, badData = 0, firstReady = -1;
      logic [7:0] expDat = 8'h00;
      applyReset();
      div_i = 8'd0; ackDelay = 0; address_bus = 16'h2000; write_enable = 1'b0; dat_i = 8'h10;
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk_i);
         if (ready) begin
            readyCount++;
            if (firstReady < 0) firstReady = i;
            if (prevReady > 0 && i - prevReady != 3) badGap++;
            prevReady = i;
            if (read_bus !== expDat) badData++;
         end
         if (ready && stb_o) overlap++;
         dat_i = dat_i + 8'h11;
         if (cyc_o) expDat = dat_i;
      end
      checks++; if (firstReady !== 2) begin errors++; $display("[TB] FAIL b2b_first_ready: got %0d expected 2", firstReady); end
      checks++; if (readyCount !== 5) begin errors++; $display("[TB] FAIL b2b_ready_count: got %0d expected 5", readyCount); end
      checks++; if (badGap !== 0) begin errors++; $display("[TB] FAIL b2b_period: got %0d bad gaps expected 0", badGap); end
      checks++; if (overlap !== 0) begin errors++; $display("[TB] FAIL b2b_ready_during_stb: got %0d expected 0", overlap); end
      checks++; if (badData !== 0) begin errors++; $display("[TB] FAIL b2b_read_data: got %0d bad reads expected 0", badData); end
   endtask

   task automatic test_div_max();
      int firstCyc = -1;
      applyReset();
      div_i = 8'hFF; ackDelay = 0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 1; i <= 300 && firstCyc < 0; i++) begin
         @(negedge clk_i);
         if (cyc_o) firstCyc = i;
      end
      checks++; if (firstCyc !== 256) begin errors++; $display("[TB] FAIL divmax_start: got %0d expected 256", firstCyc); end
   endtask

   task automatic test_halt();
      int bad = 0, firstCyc = -1, badAfter = 0;
      logic readySeen;
      applyReset();
      div_i = 8'd2; ackDelay = 0; halt_i = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk_i);
         ackForce = (i == 5);
         if (cyc_o || ready) bad++;
      end
      ackForce = 1'b0;
      halt_i = 1'b0;
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL halt_idle: got %0d active cycles expected 0", bad); end
      for (int j = 1; j <= 10 && firstCyc < 0; j++) begin
         @(negedge clk_i);
         if (cyc_o) firstCyc = j;
      end
      checks++; if (firstCyc !== 3) begin errors++; $display("[TB] FAIL halt_resume: got %0d expected 3", firstCyc); end
      halt_i = 1'b1;
      @(negedge clk_i);
      readySeen = ready;
      checks++; if (readySeen !== 1'b1) begin errors++; $display("[TB] FAIL halt_done_ready: got %b expected 1", readySeen); end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk_i);
         if (cyc_o || ready) badAfter++;
      end
      halt_i = 1'b0;
      checks++; if (badAfter !== 0) begin errors++; $display("[TB] FAIL halt_frozen: got %0d active cycles expected 0", badAfter); end
   endtask

   task automatic test_reset_mid_req();
      applyReset();
      div_i = 8'd0; ackDelay = 5; address_bus = 16'h4321; write_bus = 8'h99; write_enable = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      checks++; if (cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL midreq_active: got %b expected 1", cyc_o); end
      rst_ni = 1'b0;
      #1;
      checks++; if ({cyc_o, stb_o, we_o} !== 3'b000) begin errors++; $display("[TB] FAIL midreq_drop: got %b expected 000", {cyc_o, stb_o, we_o}); end
      checks++; if ({adr_o, dat_o, read_bus} !== 32'h0) begin errors++; $display("[TB] FAIL midreq_values: got %h expected 0", {adr_o, dat_o, read_bus}); end
      @(negedge clk_i);
      checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL midreq_ready: got %b expected 0", ready); end
      write_enable = 1'b0; ackDelay = 0;
   endtask

`ifdef WB_TIMEOUT_EN
   task automatic test_timeout();
      int reqCycles = 0, readyCycle = -1, secondReady = -1;
      logic [7:0] abortData = 8'h00;
      applyReset();
      div_i = 8'd0; ackEnable = 1'b0; address_bus = 16'h3000; write_enable = 1'b0; dat_i = 8'h3C;
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 1; i <= 20 && readyCycle < 0; i++) begin
         @(negedge clk_i);
         if (cyc_o) reqCycles++;
         if (ready) begin readyCycle = i; abortData = read_bus; end
      end
      ackEnable = 1'b1;
      checks++; if (reqCycles !== 8) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d expected 8", reqCycles); end
      checks++; if (abortData !== 8'hFF) begin errors++; $display("[TB] FAIL timeout_read_bus: got %h expected ff", abortData); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", err_o); end
      for (int i = 1; i <= 10 && secondReady < 0; i++) begin
         @(negedge clk_i);
         if (ready) secondReady = i;
      end
      checks++; if (secondReady !== 3 || read_bus !== 8'h3C) begin errors++; $display("[TB] FAIL timeout_recover: got cycle %0d data %h expected cycle 3 data 3c", secondReady, read_bus); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_sticky: got %b expected 1", err_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_div_max();
      test_halt();
      test_reset_mid_req();
`ifdef WB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
